dds_ctrl: RTL
=============

DDS_CTRL -- requirements
Module: dds_ctrl

Interface
REQ-001 SHALL have parameters: ACC_W, default 32, phase accumulator width; ADDR_W, default 12, sine ROM address width; DATA_W, default 8, ROM sample width; ROM_LAT, default 1, ROM read latency in cycles.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin generation.
REQ-005 SHALL have port stop, input, 1, single-cycle request to end generation.
REQ-006 SHALL have port ftw_in, input, ACC_W, frequency tuning word.
REQ-007 SHALL have port ftw_load, input, 1, capture strobe for ftw_in.
REQ-008 SHALL have port div_in, input, 16, sample-rate divisor; one sample every div_in+1 clocks.
REQ-009 SHALL have port phase_off, input, ADDR_W, static phase offset (used only with REQ-029).
REQ-010 SHALL have port rom_addr, output, ADDR_W, registered address to the sine ROM.
REQ-011 SHALL have port rom_data, input, DATA_W, ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-012 SHALL have port dac_data, output, DATA_W, registered sample to the DAC.
REQ-013 SHALL have port dac_valid, output, 1, one-cycle pulse per new dac_data.
REQ-014 SHALL have port busy, output, 1, high in RUN and DRAIN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-016 IDLE->RUN on start=1 with stop=0; start and stop together in IDLE SHALL stay IDLE.
REQ-017 On IDLE->RUN the accumulator, divider counter and latency pipe SHALL clear to 0; the shadow FTW SHALL copy to the active FTW.
REQ-018 Divider SHALL count 0..div_in; sample tick SHALL fire when count==div_in, then count returns to 0; div_in=0 SHALL tick every cycle in RUN.
REQ-019 On each tick in RUN: acc <= acc + active FTW, modulo 2^ACC_W; rom_addr <= acc[ACC_W-1 -: ADDR_W] using the pre-add value.
REQ-020 First tick after start SHALL issue rom_addr=0.
REQ-021 A tick-valid flag SHALL be delayed ROM_LAT+1 cycles; when it emerges, dac_data <= rom_data and dac_valid=1 for one cycle.
REQ-022 ftw_load SHALL capture ftw_in into a shadow register in any state; active FTW SHALL update from shadow only on a tick, never mid-sample.
REQ-023 start in RUN or DRAIN SHALL be ignored.
REQ-024 stop in RUN SHALL enter DRAIN; no further ticks or address changes; DRAIN SHALL last until all in-flight samples emerge (ROM_LAT+1 cycles), then IDLE.
REQ-025 On entering IDLE from DRAIN, dac_data SHALL go to midscale (MSB=1, rest 0) the cycle after the last dac_valid.
REQ-026 stop in IDLE or DRAIN SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state IDLE, acc 0, active and shadow FTW 0, divider 0, pipe 0, rom_addr 0, dac_data midscale, dac_valid 0, busy 0.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL discard in-flight samples; no dac_valid after release until a new start.

Configuration
REQ-029 Macro DDS_PHASE_OFFSET_EN defined: rom_addr SHALL equal acc MSBs + phase_off, modulo 2^ADDR_W. Undefined: phase_off SHALL be unused, with no adder.

Structure
REQ-030 A shared package dds_pkg SHALL hold the FSM state enum, default widths and the MIDSCALE constant.
REQ-031 The divider SHALL be a sub-module dds_tick_div (count, div_in, enable, tick).
REQ-032 The ROM SHALL stay external; dds_ctrl drives only rom_addr.

Verification
REQ-033 Defaults: div_in=0, ftw=0x00100000, start -> rom_addr 0,1,2,... each cycle; first dac_valid 2 cycles after first address.
REQ-034 div_in=3 -> dac_valid exactly every 4 cycles; rom_addr steps once per 4 cycles.
REQ-035 ftw=0xFFF00000 -> rom_addr 0, 0xFFF, 0xFFE (wrap-around checked).
REQ-036 ftw_load mid-interval with div_in=7 -> new step seen only from the next tick; no partial step.
REQ-037 stop in RUN -> exactly the in-flight dac_valid pulses, then busy=0 and dac_data=0x80; start+stop in IDLE -> busy stays 0.
REQ-038 rst_n low mid-RUN -> outputs at reset values immediately; with DDS_PHASE_OFFSET_EN and phase_off=0x400, first address=0x400.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg
// Shared definitions for the DDS controller slice: the controller FSM state
// type, the default parameter widths and the DAC midscale code.
// Build option: DDS_PHASE_OFFSET_EN (consumed by dds_ctrl, not used here).
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dds_state_t;

  localparam int DEF_ACC_W   = 32;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ROM_LAT = 1;
  localparam int DIV_W       = 16;

  // Offset-binary midscale for a DAC of the given width: MSB set, rest clear.
  function automatic logic [31:0] midscale_code(input int width);
    return 32'd1 << (width - 1);
  endfunction

  localparam logic [DEF_DATA_W-1:0] MIDSCALE = DEF_DATA_W'(midscale_code(DEF_DATA_W));

endpackage

// File: rtl/dds_tick_div.sv
// dds_tick_div
// Sample-rate divider: while enabled, counts 0..div_in and raises tick on the
// cycle where count equals div_in, after which the count wraps to 0.
// div_in = 0 therefore ticks on every enabled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart of the count at 0
//   enable     : count advances and tick may fire only while high
//   div_in     : divisor, one tick every div_in+1 enabled cycles
//   count      : current count value
//   tick       : sample strobe (combinational from count)
module dds_tick_div
  import dds_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic [DIV_WIDTH-1:0] count,
  output logic                 tick
);

  assign tick = enable && (count == div_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dds_ctrl.sv
// dds_ctrl
// Direct digital synthesis controller. A phase accumulator advances by the
// active frequency tuning word once per divider tick; its MSBs address an
// external sine ROM and the returned sample is forwarded to the DAC once the
// ROM latency has elapsed.
// Build option: DDS_PHASE_OFFSET_EN adds phase_off to the ROM address
// (modulo 2^ADDR_W); without it phase_off is ignored.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, stop    : single-cycle run / halt requests
//   ftw_in/ftw_load: tuning word and its capture strobe (into a shadow reg)
//   div_in         : one sample every div_in+1 clocks
//   phase_off      : static ROM address offset (option only)
//   rom_addr       : registered sine ROM address
//   rom_data       : ROM sample, valid ROM_LAT cycles after rom_addr
//   dac_data       : registered DAC sample, dac_valid pulses per new sample
//   busy           : high while running or draining
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_load,
  input  logic [15:0]       div_in,
  input  logic [ADDR_W-1:0] phase_off,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy
);

  localparam logic [DATA_W-1:0] MID_CODE = DATA_W'(midscale_code(DATA_W));
  localparam int DRAIN_W = $clog2(ROM_LAT + 1) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ROM_LAT);

  dds_state_t state, state_next;

  logic               launch;
  logic               run_en;
  logic               drain_done;
  logic               tick;
  logic [15:0]        unused_div_count;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_active;
  logic [ACC_W-1:0]   ftw_shadow;
  logic [ROM_LAT:0]   pipe;
  logic [ROM_LAT:0]   pipe_in;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ADDR_W-1:0]  addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start && !stop)           state_next = ST_RUN;
      ST_RUN:   if (stop)                     state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST)  state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // A stop request suppresses the tick in its own cycle so that no sample is
  // issued once halting has been requested.
  always_comb begin
    busy       = 1'b0;
    launch     = 1'b0;
    run_en     = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      ST_IDLE:  launch = start && !stop;
      ST_RUN: begin
        busy   = 1'b1;
        run_en = !stop;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        drain_done = (drain_cnt == DRAIN_LAST);
      end
      default: ;
    endcase
  end

  // The count is kept for debug visibility only; the controller uses tick.
  dds_tick_div #(
    .DIV_WIDTH (16)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (launch),
    .enable (run_en),
    .div_in (div_in),
    .count  (unused_div_count),
    .tick   (tick)
  );

  // DRAIN holds for ROM_LAT+1 cycles, enough for the last issued address to
  // come back through the ROM and the DAC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state != ST_DRAIN) begin
      drain_cnt <= '0;
    end else if (!drain_done) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

`ifdef DDS_PHASE_OFFSET_EN
  assign addr_next = acc[ACC_W-1 -: ADDR_W] + phase_off;
`else
  logic unused_phase_off;
  assign addr_next        = acc[ACC_W-1 -: ADDR_W];
  assign unused_phase_off = ^phase_off;
`endif

  always_comb begin
    pipe_in    = '0;
    pipe_in[0] = tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_shadow <= '0;
    end else if (ftw_load) begin
      ftw_shadow <= ftw_in;
    end
  end

  // The address uses the pre-add accumulator, so the first tick after start
  // reads address 0. The active word is refreshed only on a tick, so a word
  // loaded mid-interval never splits a sample step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ftw_active <= '0;
      rom_addr   <= '0;
      pipe       <= '0;
    end else if (launch) begin
      acc        <= '0;
      ftw_active <= ftw_shadow;
      pipe       <= '0;
    end else begin
      pipe <= (pipe << 1) | pipe_in;
      if (tick) begin
        acc        <= acc + ftw_active;
        ftw_active <= ftw_shadow;
        rom_addr   <= addr_next;
      end
    end
  end

  // The MSB of the valid pipe marks the cycle the ROM word for an issued
  // address is present on rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data  <= MID_CODE;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= pipe[ROM_LAT];
      if (pipe[ROM_LAT]) begin
        dac_data <= rom_data;
      end else if (drain_done) begin
        dac_data <= MID_CODE;
      end
    end
  end

endmodule
